// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution unit.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_func_e;

    localparam int unsigned CNT_WIDTH = 16;
    localparam logic [1:0]  BHT_RESET = 2'b01;

    // 2-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] bht_next(logic [1:0] ctr, logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Request/result handshake bundle between the issue stage and the branch unit.
interface branch_resolve_if #(
    parameter int unsigned DWIDTH = 32
);
    import branch_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DWIDTH-1:0]    A;
    logic [DWIDTH-1:0]    B;
    logic [2:0]           brfunc;
    logic [DWIDTH-1:0]    pc;
    logic [DWIDTH-1:0]    imm;
    logic                 pred_taken;
    logic                 out_valid;
    logic                 out_ready;
    logic                 taken;
    logic [DWIDTH-1:0]    target;
    logic                 mispredict;
    logic [DWIDTH-1:0]    redirect_pc;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] br_count;
    logic [CNT_WIDTH-1:0] mp_count;

    modport master (
        output in_valid, A, B, brfunc, pc, imm, pred_taken, out_ready,
        input  in_ready, out_valid, taken, target, mispredict, redirect_pc, illegal,
               br_count, mp_count
    );

    modport slave (
        input  in_valid, A, B, brfunc, pc, imm, pred_taken, out_ready,
        output in_ready, out_valid, taken, target, mispredict, redirect_pc, illegal,
               br_count, mp_count
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational funct3 decode and operand comparison for conditional branches.
module branch_cond
    import branch_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    input  logic [2:0]        brfunc,
    output logic              taken,
    output logic              illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_func_e'(brfunc))
            BR_BEQ:  taken = (A == B);
            BR_BNE:  taken = (A != B);
            BR_BLT:  taken = ($signed(A) < $signed(B));
            BR_BGE:  taken = ($signed(A) >= $signed(B));
            BR_BLTU: taken = (A < B);
            BR_BGEU: taken = (A >= B);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Single-stage registered branch resolver with handshake and event counters.
// Optional branch history table enabled by defining BRANCH_BHT_EN.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned BHT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus
`ifdef BRANCH_BHT_EN
    ,
    input  logic [DWIDTH-1:0] lookup_pc,
    output logic              bht_pred
`endif
);

    logic                 cond_taken;
    logic                 cond_illegal;
    logic                 accept;
    logic                 out_hs;
    logic [DWIDTH-1:0]    sum_target;
    logic [DWIDTH-1:0]    seq_pc;
    logic                 mp_new;

    logic                 valid_q;
    logic                 taken_q;
    logic                 illegal_q;
    logic                 mispredict_q;
    logic [DWIDTH-1:0]    target_q;
    logic [DWIDTH-1:0]    redirect_q;
    logic [CNT_WIDTH-1:0] br_count_q;
    logic [CNT_WIDTH-1:0] mp_count_q;

    branch_cond #(
        .DWIDTH (DWIDTH)
    ) u_cond (
        .A       (bus.A),
        .B       (bus.B),
        .brfunc  (bus.brfunc),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_hs       = valid_q && bus.out_ready;
    assign sum_target   = bus.pc + bus.imm;
    assign seq_pc       = bus.pc + DWIDTH'(4);
    assign mp_new       = cond_illegal || (cond_taken != bus.pred_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            mispredict_q <= 1'b0;
            target_q     <= '0;
            redirect_q   <= '0;
            br_count_q   <= '0;
            mp_count_q   <= '0;
        end else begin
            // Counters account for the result leaving, not the one arriving.
            if (out_hs) begin
                if (br_count_q != '1) begin
                    br_count_q <= br_count_q + CNT_WIDTH'(1);
                end
                if (mispredict_q && (mp_count_q != '1)) begin
                    mp_count_q <= mp_count_q + CNT_WIDTH'(1);
                end
            end
            if (accept) begin
                valid_q      <= 1'b1;
                taken_q      <= cond_taken;
                illegal_q    <= cond_illegal;
                mispredict_q <= mp_new;
                target_q     <= sum_target;
                redirect_q   <= cond_taken ? sum_target : seq_pc;
            end else if (out_hs) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.taken       = taken_q;
    assign bus.illegal     = illegal_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.target      = target_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.br_count    = br_count_q;
    assign bus.mp_count    = mp_count_q;

`ifdef BRANCH_BHT_EN
    localparam int unsigned IdxW = $clog2(BHT_DEPTH);

    logic [1:0]      bht_q [BHT_DEPTH];
    logic [IdxW-1:0] idx_q;
    logic            unused_lookup;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= BHT_RESET;
            end
        end else begin
            if (accept) begin
                idx_q <= bus.pc[IdxW+1:2];
            end
            if (out_hs && !illegal_q) begin
                bht_q[idx_q] <= bht_next(bht_q[idx_q], taken_q);
            end
        end
    end

    // Reads the registered table, so a same-cycle update shows the old value.
    assign bht_pred      = bht_q[lookup_pc[IdxW+1:2]][1];
    assign unused_lookup = ^{lookup_pc[DWIDTH-1:IdxW+2], lookup_pc[1:0]};
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a per-cycle behavioural reference model.
module tb_branch_resolve;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_resolve_if #(.DWIDTH(32)) bus ();

`ifdef BRANCH_BHT_EN
    logic [31:0] lookup_pc;
    logic        bht_pred;
`endif

    branch_resolve #(
        .DWIDTH    (32),
        .BHT_DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef BRANCH_BHT_EN
        ,
        .lookup_pc (lookup_pc),
        .bht_pred  (bht_pred)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    typedef struct packed {
        logic        taken;
        logic        ill;
        logic        mp;
        logic [31:0] target;
        logic [31:0] redirect;
    } res_t;

    function automatic res_t resolve(logic [31:0] a, logic [31:0] b, logic [2:0] f,
                                     logic [31:0] pc, logic [31:0] imm, logic pred);
        res_t   r;
        longint sa  = longint'($signed(a));
        longint sb  = longint'($signed(b));
        longint ua  = longint'({32'd0, a});
        longint ub  = longint'({32'd0, b});
        longint pcl = longint'({32'd0, pc});
        longint iml = longint'({32'd0, imm});
        r.ill = (f == 3'd2) || (f == 3'd3);
        case (f)
            3'd0:    r.taken = (ua == ub);
            3'd1:    r.taken = (ua != ub);
            3'd4:    r.taken = (sa < sb);
            3'd5:    r.taken = (sa >= sb);
            3'd6:    r.taken = (ua < ub);
            3'd7:    r.taken = (ua >= ub);
            default: r.taken = 1'b0;
        endcase
        r.target   = 32'((pcl + iml) % 64'h1_0000_0000);
        r.redirect = r.taken ? r.target : 32'((pcl + 4) % 64'h1_0000_0000);
        r.mp       = r.ill || (r.taken != pred);
        return r;
    endfunction

    // Reference state: what the outputs must show during the current cycle.
    bit   known = 0;
    bit   m_valid;
    res_t m;
    int   m_br, m_mp, m_idx;
    int   bht [16];

    always @(negedge clk) begin
        bit hs, acc;
        if (known) begin
            check("out_valid", bus.out_valid, m_valid);
            check("in_ready", bus.in_ready, !m_valid || bus.out_ready);
            check("br_count", bus.br_count, m_br);
            check("mp_count", bus.mp_count, m_mp);
            if (m_valid) begin
                check("taken", bus.taken, m.taken);
                check("illegal", bus.illegal, m.ill);
                check("mispredict", bus.mispredict, m.mp);
                check("target", bus.target, m.target);
                check("redirect_pc", bus.redirect_pc, m.redirect);
            end
`ifdef BRANCH_BHT_EN
            check("bht_pred", bht_pred, bht[(lookup_pc >> 2) % 16] >= 2);
`endif
        end
        if (reset) begin
            known   = 1;
            m_valid = 0;
            m       = '0;
            m_br    = 0;
            m_mp    = 0;
            m_idx   = 0;
            foreach (bht[i]) bht[i] = 1;
        end else if (known) begin
            hs  = m_valid && bus.out_ready;
            acc = bus.in_valid && (!m_valid || bus.out_ready);
            if (hs) begin
                if (m_br < 65535) m_br++;
                if (m.mp && m_mp < 65535) m_mp++;
                if (!m.ill) begin
                    if (m.taken) bht[m_idx] = (bht[m_idx] < 3) ? bht[m_idx] + 1 : 3;
                    else         bht[m_idx] = (bht[m_idx] > 0) ? bht[m_idx] - 1 : 0;
                end
            end
            if (acc) begin
                m       = resolve(bus.A, bus.B, bus.brfunc, bus.pc, bus.imm, bus.pred_taken);
                m_idx   = (bus.pc >> 2) % 16;
                m_valid = 1;
            end else if (hs) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] a, logic [31:0] b, logic [2:0] f,
                         logic [31:0] pc, logic [31:0] imm, logic pred);
        bus.in_valid   = 1'b1;
        bus.A          = a;
        bus.B          = b;
        bus.brfunc     = f;
        bus.pc         = pc;
        bus.imm        = imm;
        bus.pred_taken = pred;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  f;
        logic [31:0] pc, imm;
        logic        pred;
        logic        rdy;
    } vec_t;

    vec_t vecs [8] = '{
        '{32'h0000_0005, 32'h8000_0000, 3'd4, 32'h1000, 32'h0000_0040, 1'b0, 1'b1},
        '{32'h8000_0000, 32'h0000_0005, 3'd6, 32'h1004, 32'hFFFF_FF00, 1'b1, 1'b0},
        '{32'h0000_0007, 32'h0000_0007, 3'd1, 32'h1008, 32'h0000_0010, 1'b0, 1'b1},
        '{32'hFFFF_FFFF, 32'h0000_0000, 3'd5, 32'h100C, 32'h0000_0020, 1'b1, 1'b1},
        '{32'h0000_0001, 32'h0000_0002, 3'd2, 32'h1010, 32'h0000_0008, 1'b1, 1'b0},
        '{32'h0000_0003, 32'h0000_0003, 3'd7, 32'h1014, 32'h0000_0004, 1'b1, 1'b1},
        '{32'h1234_5678, 32'h1234_5679, 3'd0, 32'h1018, 32'h0000_000C, 1'b0, 1'b1},
        '{32'h0000_0000, 32'hFFFF_FFFF, 3'd6, 32'h101C, 32'h0000_0100, 1'b0, 1'b1}
    };

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.A          = '0;
        bus.B          = '0;
        bus.brfunc     = '0;
        bus.pc         = '0;
        bus.imm        = '0;
        bus.pred_taken = 1'b0;
`ifdef BRANCH_BHT_EN
        lookup_pc      = 32'h40;
`endif
        step();
        step();
        reset = 1'b0;
        check("rst out_valid", bus.out_valid, 0);
        check("rst in_ready", bus.in_ready, 1);
        check("rst br_count", bus.br_count, 0);
        check("rst target", bus.target, 0);

        // Signed versus unsigned compare of -1 and 1.
        drive(32'hFFFF_FFFF, 32'h1, 3'b100, 32'h100, 32'h20, 1'b1);
        step();
        check("blt taken", bus.taken, 1);
        check("blt redirect", bus.redirect_pc, 32'h120);
        drive(32'hFFFF_FFFF, 32'h1, 3'b110, 32'h100, 32'h20, 1'b1);
        step();
        check("bltu taken", bus.taken, 0);
        check("bltu mispredict", bus.mispredict, 1);
        check("bltu redirect", bus.redirect_pc, 32'h104);
        check("br_count 1", bus.br_count, 1);

        // PC wrap-around on target and fall-through.
        drive(32'h5, 32'h5, 3'b000, 32'hFFFF_FFFC, 32'h8, 1'b1);
        step();
        check("wrap target", bus.target, 32'h4);
        check("wrap redirect taken", bus.redirect_pc, 32'h4);
        drive(32'h5, 32'h6, 3'b000, 32'hFFFF_FFFC, 32'h8, 1'b1);
        step();
        check("wrap redirect seq", bus.redirect_pc, 32'h0);

        // Illegal funct3.
        drive(32'h0, 32'h0, 3'b011, 32'h10, 32'h10, 1'b0);
        step();
        check("ill illegal", bus.illegal, 1);
        check("ill mispredict", bus.mispredict, 1);
        check("ill taken", bus.taken, 0);
        check("mp_count before", bus.mp_count, 2);
        bus.in_valid = 1'b0;
        step();
        check("mp_count after", bus.mp_count, 3);
        check("br_count 5", bus.br_count, 5);

        // Backpressure hold then back-to-back throughput.
        bus.out_ready = 1'b0;
        drive(32'h1, 32'h2, 3'b100, 32'h200, 32'h10, 1'b1);
        step();
        drive(32'h1, 32'h2, 3'b001, 32'h300, 32'h4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall in_ready", bus.in_ready, 0);
            check("stall target", bus.target, 32'h210);
            check("stall redirect", bus.redirect_pc, 32'h210);
        end
        bus.out_ready = 1'b1;
        step();
        check("b2b r1 target", bus.target, 32'h304);
        drive(32'h1, 32'hFFFF_FFFF, 3'b111, 32'h400, 32'hFFFF_FFFC, 1'b0);
        step();
        check("b2b r2 target", bus.target, 32'h3FC);
        check("b2b r2 redirect", bus.redirect_pc, 32'h404);
        drive(32'hFFFF_FFFB, 32'hFFFF_FFFB, 3'b101, 32'h500, 32'h0, 1'b1);
        step();
        check("b2b r3 redirect", bus.redirect_pc, 32'h500);
        check("b2b r3 valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        step();
        check("b2b br_count", bus.br_count, 9);

        // Mixed vectors with intermittent backpressure.
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].pc, vecs[i].imm, vecs[i].pred);
            bus.out_ready = vecs[i].rdy;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();

        // Reset mid-flight discards the held result and overrides the handshake.
        drive(32'h9, 32'h9, 3'b000, 32'h600, 32'h8, 1'b0);
        bus.out_ready = 1'b0;
        step();
        check("pre-rst valid", bus.out_valid, 1);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("mid-rst out_valid", bus.out_valid, 0);
        check("mid-rst br_count", bus.br_count, 0);
        check("mid-rst mp_count", bus.mp_count, 0);
        check("mid-rst redirect", bus.redirect_pc, 0);
        step();
        check("post-rst in_ready", bus.in_ready, 1);

`ifdef BRANCH_BHT_EN
        // Three taken branches at 0x40 walk the counter 01 -> 10 -> 11 -> 11.
        lookup_pc = 32'h40;
        check("bht init", bht_pred, 0);
        drive(32'h3, 32'h3, 3'b000, 32'h40, 32'h8, 1'b0);
        step();
        check("bht before update", bht_pred, 0);
        step();
        check("bht after 1", bht_pred, 1);
        step();
        check("bht after 2", bht_pred, 1);
        bus.in_valid = 1'b0;
        step();
        check("bht after 3", bht_pred, 1);
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: operand width, also PC/target width.
REQ-002 SHALL have parameter BHT_DEPTH, default 16: branch history table entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge; reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_ready, output, 1 bit: request accepted when in_valid && in_ready.
REQ-007 SHALL have ports A and B, input, DWIDTH bits each: rs1/rs2 operands.
REQ-008 SHALL have port brfunc, input, 3 bits: funct3.
REQ-009 SHALL have ports pc and imm, input, DWIDTH bits each: branch PC and sign-extended offset.
REQ-010 SHALL have port pred_taken, input, 1 bit: fetch-stage prediction.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port taken, output, 1 bit: resolved condition.
REQ-014 SHALL have port target, output, DWIDTH bits: pc+imm.
REQ-015 SHALL have port mispredict, output, 1 bit: taken != pred_taken, or illegal.
REQ-016 SHALL have port redirect_pc, output, DWIDTH bits: correct next PC.
REQ-017 SHALL have port illegal, output, 1 bit: brfunc is 010 or 011.
REQ-018 SHALL have ports br_count and mp_count, output, 16 bits each: resolved-branch and mispredict counters.

Function
REQ-019 SHALL decode brfunc 000 beq, 001 bne, 100 blt, 101 bge (signed compare), 110 bltu, 111 bgeu (unsigned compare of both A and B).
REQ-020 SHALL set taken=0 and illegal=1 for brfunc 010 and 011.
REQ-021 SHALL compute target = pc+imm modulo 2^DWIDTH; wrap-around is not flagged.
REQ-022 SHALL set redirect_pc = target if taken, else pc+4 (modulo 2^DWIDTH).
REQ-023 SHALL register all results with latency exactly 1 cycle from acceptance to out_valid.
REQ-024 SHALL drive in_ready = !out_valid || out_ready, giving full throughput with no bubbles.
REQ-025 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-026 SHALL clear out_valid on an out handshake with no new acceptance in the same cycle.
REQ-027 SHALL, on simultaneous out handshake and in acceptance, load the new result with out_valid remaining 1.
REQ-028 SHALL increment br_count on each out handshake, and mp_count on each out handshake with mispredict=1; both saturate at 16'hFFFF.

Reset
REQ-029 SHALL, with reset asserted at a clk edge, clear out_valid, taken, mispredict, illegal, target, redirect_pc, br_count and mp_count to 0; reset overrides any handshake in that cycle.
REQ-030 SHALL discard any in-flight result on reset mid-operation; it is not counted.
REQ-031 SHALL drive in_ready=1 in the cycle after reset deasserts.

Configuration
REQ-032 SHALL, with BRANCH_BHT_EN defined, contain BHT_DEPTH 2-bit saturating counters indexed by pc[log2(BHT_DEPTH)+1:2], reset to 2'b01 (weakly not-taken).
REQ-033 SHALL, with BRANCH_BHT_EN defined, add input lookup_pc (DWIDTH bits) and output bht_pred (1 bit, combinational, counter MSB).
REQ-034 SHALL, with BRANCH_BHT_EN defined, update the indexed counter on each out handshake (increment if taken, else decrement, saturating); illegal results do not update.
REQ-035 SHALL, with BRANCH_BHT_EN defined, make bht_pred show the old counter value when lookup and update hit the same index in one cycle.
REQ-036 SHALL, without BRANCH_BHT_EN, contain no table, no lookup_pc port and no bht_pred port.

Structure
REQ-037 SHALL place the funct3 enum (BR_BEQ..BR_BGEU), the counter width constant (16) and the BHT reset value in shared package branch_pkg.
REQ-038 SHALL implement the condition logic as combinational sub-module branch_cond (A, B, brfunc -> taken, illegal).

Verification
REQ-039 SHALL test: A=-1, B=1, brfunc=100 -> taken=1; brfunc=110 -> taken=0.
REQ-040 SHALL test: pc=32'hFFFF_FFFC, imm=8, beq with A==B -> target=32'h4, redirect_pc=32'h4; with A!=B -> redirect_pc=32'h0.
REQ-041 SHALL test: out_ready low 3 cycles with a result held -> outputs stable, in_ready=0; then 3 back-to-back requests -> 3 results on 3 consecutive cycles.
REQ-042 SHALL test: brfunc=011, pred_taken=0 -> illegal=1, mispredict=1, mp_count increments by 1.
REQ-043 SHALL test: reset asserted while out_valid=1 -> next cycle out_valid=0, counters=0, in_ready=1.
REQ-044 SHALL test, with BRANCH_BHT_EN: 3 taken branches at pc=0x40 -> bht_pred for lookup_pc=0x40 goes 0,1,1 (counter 01->10->11->11).
